// File: rtl/uart_defs.sv
// Shared UART definitions: FSM state encodings, clog2 and bit-period derivation.
// Latency: n/a (package only).
// Backpressure: n/a; used by both the transmitter and the receiver.
// Optional feature macro: UART_TX_PARITY_EN adds the PARITY state encoding.
package uart_defs;

   // The encodings are fixed so that transmitter and receiver agree on them.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      ST_PARITY = 3'd3,
`endif
      ST_STOP   = 3'd4
   } uart_state_t;

   // Ceiling log2: the number of bits needed to index 'value' distinct items.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   // Clock cycles per line bit, truncating integer division.
   function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
      return clk_hz / bit_rate;
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter that flags the end of a bit period.
// Latency: tc is high while the count is zero; a load takes effect on the next edge.
// Backpressure: none; the count stops at zero until reloaded and never wraps.
// Ports: clk, resetn (async, active-low), load / load_val (reload strobe and value),
//        tc (terminal count, combinational from the count register).
module uart_bit_timer #(
   parameter int W = 13
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         tc
);

   logic [W-1:0] count;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - W'(1);
      end
   end

   assign tc = (count == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, payload LSB-first, optional even parity, stop bit(s).
// Latency: uart_txd goes low on the edge after an accepted request; frame is
//          (1+PAYLOAD_BITS+P+STOP_BITS)*CYCLES_PER_BIT cycles long.
// Backpressure: uart_tx_en is only sampled while uart_tx_busy=0; requests while busy are dropped.
// Ports: clk, resetn (async, active-low), uart_tx_en / uart_tx_data (request and payload),
//        uart_tx_busy (frame in flight), uart_txd (serial line, idle high, registered).
// Optional feature macro: UART_TX_PARITY_EN inserts an even-parity bit after the data bits.
module uart_tx
   import uart_defs::*;
#(
   parameter int BIT_RATE     = 11520,
   parameter int CLK_HZ       = 50000000,
   parameter int PAYLOAD_BITS = 8,
   parameter int STOP_BITS    = 1
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    uart_tx_en,
   input  logic [PAYLOAD_BITS-1:0] uart_tx_data,
   output logic                    uart_tx_busy,
   output logic                    uart_txd
);

   localparam int CYCLES_PER_BIT = cycles_per_bit(CLK_HZ, BIT_RATE);
   localparam int CNT_W          = clog2(CYCLES_PER_BIT + 1);
   localparam int IDX_W          = clog2(PAYLOAD_BITS + 1);

   localparam logic [CNT_W-1:0] BIT_RELOAD = CNT_W'(CYCLES_PER_BIT - 1);
   localparam logic [IDX_W-1:0] LAST_DATA  = IDX_W'(PAYLOAD_BITS - 1);
   localparam logic [IDX_W-1:0] LAST_STOP  = IDX_W'(STOP_BITS - 1);

   uart_state_t             state;
   logic [PAYLOAD_BITS-1:0] shreg;
   logic [PAYLOAD_BITS-1:0] shifted;
   logic [IDX_W-1:0]        bit_idx;
   logic                    tc;
   logic                    timer_load;
`ifdef UART_TX_PARITY_EN
   logic                    parity_bit;
`endif

   assign shifted = shreg >> 1;

   // Timer is armed on acceptance and re-armed at every bit boundary, so the
   // next boundary always lands exactly CYCLES_PER_BIT edges later.
   assign timer_load = (state == ST_IDLE) ? uart_tx_en : tc;

   uart_bit_timer #(
      .W (CNT_W)
   ) u_bit_timer (
      .clk      (clk),
      .resetn   (resetn),
      .load     (timer_load),
      .load_val (BIT_RELOAD),
      .tc       (tc)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state        <= ST_IDLE;
         uart_txd     <= 1'b1;
         uart_tx_busy <= 1'b0;
         shreg        <= '0;
         bit_idx      <= '0;
`ifdef UART_TX_PARITY_EN
         parity_bit   <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               uart_txd     <= 1'b1;
               uart_tx_busy <= 1'b0;
               if (uart_tx_en) begin
                  shreg        <= uart_tx_data;
`ifdef UART_TX_PARITY_EN
                  parity_bit   <= ^uart_tx_data;
`endif
                  bit_idx      <= '0;
                  state        <= ST_START;
                  uart_txd     <= 1'b0;
                  uart_tx_busy <= 1'b1;
               end
            end
            ST_START: begin
               if (tc) begin
                  state    <= ST_DATA;
                  uart_txd <= shreg[0];
               end
            end
            ST_DATA: begin
               if (tc) begin
                  if (bit_idx == LAST_DATA) begin
                     bit_idx  <= '0;
`ifdef UART_TX_PARITY_EN
                     state    <= ST_PARITY;
                     uart_txd <= parity_bit;
`else
                     state    <= ST_STOP;
                     uart_txd <= 1'b1;
`endif
                  end else begin
                     // Shift register keeps the next bit at position 0.
                     bit_idx  <= bit_idx + IDX_W'(1);
                     shreg    <= shifted;
                     uart_txd <= shifted[0];
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
               if (tc) begin
                  state    <= ST_STOP;
                  uart_txd <= 1'b1;
               end
            end
`endif
            ST_STOP: begin
               // bit_idx is reused to count stop bits so the timer width
               // only has to cover a single bit period.
               if (tc) begin
                  if (bit_idx == LAST_STOP) begin
                     state        <= ST_IDLE;
                     uart_tx_busy <= 1'b0;
                     uart_txd     <= 1'b1;
                     bit_idx      <= '0;
                  end else begin
                     bit_idx <= bit_idx + IDX_W'(1);
                  end
               end
            end
            default: begin
               state        <= ST_IDLE;
               uart_txd     <= 1'b1;
               uart_tx_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx with a short bit period (10 clocks per bit).
// A line monitor decodes each frame at mid-bit and compares it with a scoreboard queue.
// Covers reset hold, single frames, back-to-back, ignored requests, mid-frame reset, parity.
module tb_uart_tx;

   localparam int BIT_RATE     = 100;
   localparam int CLK_HZ       = 1000;
   localparam int PAYLOAD_BITS = 8;
   localparam int STOP_BITS    = 1;
   localparam int CPB          = CLK_HZ / BIT_RATE;
   localparam int PERIOD       = 10;
`ifdef UART_TX_PARITY_EN
   localparam int PAR_BITS     = 1;
`else
   localparam int PAR_BITS     = 0;
`endif
   localparam int FRAME_BITS   = 1 + PAYLOAD_BITS + PAR_BITS + STOP_BITS;
   localparam int FRAME_LEN    = FRAME_BITS * CPB;

   logic       clk = 1'b0;
   logic       resetn;
   logic       uart_tx_en;
   logic [7:0] uart_tx_data;
   logic       uart_tx_busy;
   logic       uart_txd;

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] exp_q[$];
   int         frames_done = 0;
   int         last_gap = 0;
   time        last_end = 0;

   always #(PERIOD/2) clk = ~clk;

   uart_tx #(
      .BIT_RATE     (BIT_RATE),
      .CLK_HZ       (CLK_HZ),
      .PAYLOAD_BITS (PAYLOAD_BITS),
      .STOP_BITS    (STOP_BITS)
   ) dut (
      .clk          (clk),
      .resetn       (resetn),
      .uart_tx_en   (uart_tx_en),
      .uart_tx_data (uart_tx_data),
      .uart_tx_busy (uart_tx_busy),
      .uart_txd     (uart_txd)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Expected line levels, bit k = level during bit period k of the frame.
   function automatic logic [31:0] frame_bits(input logic [7:0] d);
      logic [31:0] f;
      f = '0;
      for (int i = 0; i < PAYLOAD_BITS; i++) f[1+i] = d[i];
      if (PAR_BITS == 1) f[1+PAYLOAD_BITS] = ^d;
      for (int s = 0; s < STOP_BITS; s++) f[1+PAYLOAD_BITS+PAR_BITS+s] = 1'b1;
      return f;
   endfunction

   // Line monitor: frame starts at the first negedge with txd low and busy high.
   initial begin : monitor
      forever begin
         @(negedge clk);
         if (resetn === 1'b1 && uart_tx_busy === 1'b1 && uart_txd === 1'b0) begin : frame
            int          cnt;
            logic [31:0] bits;
            logic        aborted;
            logic [7:0]  exp;
            last_gap = int'(($time - last_end) / PERIOD);
            cnt      = 0;
            bits     = '0;
            aborted  = 1'b0;
            while (uart_tx_busy === 1'b1 && cnt < FRAME_LEN + 4*CPB) begin
               if (resetn !== 1'b1) aborted = 1'b1;
               if ((cnt % CPB) == CPB/2 && (cnt / CPB) < 32) bits[cnt/CPB] = uart_txd;
               cnt++;
               @(negedge clk);
            end
            if (resetn !== 1'b1) aborted = 1'b1;
            last_end = $time;
            if (!aborted) begin
               check("frame_len", cnt, FRAME_LEN);
               check("sb_has_entry", exp_q.size() != 0, 1);
               if (exp_q.size() != 0) begin
                  exp = exp_q.pop_front();
                  check("frame_bits", bits, frame_bits(exp));
                  check("rx_data", bits[PAYLOAD_BITS:1], exp);
               end
               frames_done++;
            end
         end
      end
   end

   task automatic wait_idle();
      int i;
      i = 0;
      while (uart_tx_busy !== 1'b0 && i < 3*FRAME_LEN) begin
         @(negedge clk);
         i++;
      end
      check("wait_idle", uart_tx_busy, 0);
   endtask

   task automatic send(input logic [7:0] d);
      wait_idle();
      uart_tx_en   = 1'b1;
      uart_tx_data = d;
      exp_q.push_back(d);
      @(negedge clk);
      uart_tx_en   = 1'b0;
      uart_tx_data = 8'($urandom);
   endtask

   task automatic wait_frames(input int target);
      int i;
      i = 0;
      while (frames_done < target && i < 3*FRAME_LEN) begin
         @(negedge clk);
         i++;
      end
      check("frames_done", frames_done >= target, 1);
   endtask

   initial begin : watchdog
      #(PERIOD*20000);
      $display("FAIL watchdog: simulation did not finish, frames_done=%0d", frames_done);
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int i;
      // Reset held with a pending request: line stays idle.
      resetn       = 1'b0;
      uart_tx_en   = 1'b1;
      uart_tx_data = 8'hFF;
      repeat (4) begin
         @(negedge clk);
         check("rst_txd", uart_txd, 1);
         check("rst_busy", uart_tx_busy, 0);
      end
      uart_tx_en = 1'b0;
      #2 resetn = 1'b1;
      repeat (30) @(negedge clk);
      check("post_rst_txd", uart_txd, 1);
      check("post_rst_busy", uart_tx_busy, 0);
      check("post_rst_frames", frames_done, 0);

      // Single frame.
      send(8'hAA);
      wait_frames(1);

      // Back-to-back with the request held high; data changes after acceptance.
      wait_idle();
      uart_tx_en   = 1'b1;
      uart_tx_data = 8'hAA;
      exp_q.push_back(8'hAA);
      @(negedge clk);
      uart_tx_data = 8'h1F;
      exp_q.push_back(8'h1F);
      i = 0;
      while (uart_tx_busy !== 1'b0 && i < 3*FRAME_LEN) begin
         @(negedge clk);
         i++;
      end
      @(negedge clk);
      uart_tx_en = 1'b0;
      check("b2b_busy", uart_tx_busy, 1);
      wait_frames(3);
      check("b2b_gap", last_gap, 1);

      // Request while busy is dropped.
      send(8'h0F);
      repeat (3*CPB) @(negedge clk);
      uart_tx_en   = 1'b1;
      uart_tx_data = 8'h55;
      @(negedge clk);
      uart_tx_en   = 1'b0;
      wait_frames(4);
      repeat (2*FRAME_LEN) @(negedge clk);
      check("ignored_busy", uart_tx_busy, 0);
      check("ignored_frames", frames_done, 4);

      // Reset during data bit 3 of 0xF0.
      send(8'hF0);
      repeat (4*CPB + CPB/2) @(negedge clk);
      check("pre_rst_bit3", uart_txd, 0);
      #2 resetn = 1'b0;
      exp_q.delete();
      #1;
      check("mid_rst_txd", uart_txd, 1);
      check("mid_rst_busy", uart_tx_busy, 0);
      @(negedge clk);
      @(negedge clk);
      #2 resetn = 1'b1;
      repeat (3) @(negedge clk);
      check("rel_txd", uart_txd, 1);
      check("rel_busy", uart_tx_busy, 0);
      send(8'h3C);
      wait_frames(5);

      // Parity-sensitive payloads, then a few random ones.
      send(8'h1F);
      wait_frames(6);
      send(8'h03);
      wait_frames(7);
      for (int k = 0; k < 3; k++) begin
         send(8'($urandom));
         wait_frames(8 + k);
      end

      check("sb_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
